// File: rtl/dsram_pkg.sv
// dsram_pkg: shared types and constants for the data_sram_resp block.
//   size_e      : transfer size encodings (informational on the bus)
//   req_entry_t : one queued request (wr, byte enables, word index, write data)
//   LFSR_SEED   : reset value of the optional response/accept jitter LFSR
package dsram_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Word index is held at its widest (addr[31:2]); the top trims it to MEM_AW.
  localparam int WIDX_W = 30;

  typedef struct packed {
    logic              wr;
    logic [3:0]        wstrb;
    logic [WIDX_W-1:0] widx;
    logic [31:0]       wdata;
  } req_entry_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/data_sram_resp_if.sv
// data_sram_resp_if: request/response bus of the data SRAM.
//   master drives req, wr, size, wstrb, addr, wdata;
//   slave  drives addr_ok (accept), data_ok (response pulse), rdata.
interface data_sram_resp_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/dsram_req_fifo.sv
// dsram_req_fifo: QDEPTH-entry in-order request queue with registered
// full/empty flags and a per-slot 3-bit saturating age counter.
//   clk, reset   : clock, synchronous active-high reset
//   i_push/i_din : enqueue (ignored when full)
//   i_pop        : dequeue head (ignored when empty)
//   o_head       : head entry, o_head_age its age since acceptance
//   o_full/o_empty : registered flags
module dsram_req_fifo
  import dsram_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  req_entry_t i_din,
  input  logic       i_pop,
  output req_entry_t o_head,
  output logic [2:0] o_head_age,
  output logic       o_full,
  output logic       o_empty
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  req_entry_t    r_slot [QDEPTH];
  logic [2:0]    r_age  [QDEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_full, r_empty;
  logic          w_push, w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop  && !r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 1'b1;
    else if (!w_push && w_pop) w_cnt_nxt = r_cnt - 1'b1;
  end

  // Ages run for every slot; only occupied slots matter, and a slot's age
  // is restarted at 0 when it is written, so it counts from acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      for (int i = 0; i < QDEPTH; i++) r_age[i] <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(QDEPTH));
      r_empty <= (w_cnt_nxt == '0);
      for (int i = 0; i < QDEPTH; i++)
        if (r_age[i] != 3'd7) r_age[i] <= r_age[i] + 1'b1;
      if (w_push) r_age[r_wp] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_slot[r_wp] <= i_din;
  end

  assign o_head     = r_slot[r_rp];
  assign o_head_age = r_age[r_rp];
  assign o_full     = r_full;
  assign o_empty    = r_empty;

endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: word SRAM behind a pipelined req/addr_ok -> data_ok bus.
// Requests are queued in order; the head is answered once it has waited
// LATENCY cycles, and the array is read/written at response time.
//   clk   : clock
//   reset : synchronous active-high; drops pending requests, keeps memory
//   bus   : data_sram_resp_if.slave (req/wr/size/wstrb/addr/wdata in,
//           addr_ok/data_ok/rdata out)
// Parameters: MEM_AW (log2 words), LATENCY (1..7), QDEPTH (pow2, >=2).
// Optional macro DSRAM_RAND_DELAY_EN: an LFSR randomly withholds addr_ok
// and delays due responses by a cycle.
module data_sram_resp
  import dsram_pkg::*;
#(
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 1,
  parameter int QDEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  data_sram_resp_if.slave   bus
);
  localparam int DEPTH = 1 << MEM_AW;

  req_entry_t        w_din, w_head;
  logic [2:0]        w_head_age;
  logic              w_full, w_empty;
  logic              w_accept, w_due, w_resp;
  logic              w_aok_gate, w_resp_gate;
  logic [MEM_AW-1:0] w_midx;
  logic [31:0]       w_rword;
  logic [31:0]       r_mem [DEPTH];

`ifdef DSRAM_RAND_DELAY_EN
  // Fibonacci LFSR, taps 8,6,5,4.
  logic [7:0] r_lfsr;
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_aok_gate  = ~r_lfsr[0];
  assign w_resp_gate = ~r_lfsr[1];
`else
  assign w_aok_gate  = 1'b1;
  assign w_resp_gate = 1'b1;
`endif

  // Full is registered, so a pop this cycle only reopens addr_ok next cycle.
  assign bus.addr_ok = !reset && !w_full && w_aok_gate;
  assign w_accept    = bus.req && bus.addr_ok;

  always_comb begin
    w_din       = '0;
    w_din.wr    = bus.wr;
    w_din.wstrb = bus.wstrb;
    w_din.widx  = WIDX_W'(bus.addr[MEM_AW+1:2]);
    w_din.wdata = bus.wdata;
  end

  dsram_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_accept),
    .i_din      (w_din),
    .i_pop      (w_resp),
    .o_head     (w_head),
    .o_head_age (w_head_age),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Head age is 0 in the cycle after acceptance, so age >= LATENCY-1 lands
  // data_ok exactly LATENCY cycles after the accepting edge; later entries
  // keep aging while queued, which keeps back-to-back traffic back-to-back.
  assign w_due  = !w_empty && (({1'b0, w_head_age} + 4'd1) >= 4'(LATENCY));
  assign w_resp = !reset && w_due && w_resp_gate;

  assign w_midx  = w_head.widx[MEM_AW-1:0];
  assign w_rword = r_mem[w_midx];

  assign bus.data_ok = w_resp;
  assign bus.rdata   = (w_resp && !w_head.wr) ? w_rword : '0;

  // No reset on the array: contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_resp && w_head.wr)
      for (int b = 0; b < 4; b++)
        if (w_head.wstrb[b]) r_mem[w_midx][8*b +: 8] <= w_head.wdata[8*b +: 8];
  end

  // size, addr[1:0] and the wrapped-away address bits do not affect behaviour.
  logic w_unused;
  assign w_unused = ^{bus.size, bus.addr, w_head.widx};

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;
  localparam int AW = 12;
  localparam int QD = 2;
  localparam int L0 = 1;
  localparam int L1 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_sram_resp_if bus0();
  data_sram_resp_if bus1();

  data_sram_resp #(.MEM_AW(AW), .LATENCY(L0), .QDEPTH(QD)) u_l1 (.clk(clk), .reset(reset), .bus(bus0));
  data_sram_resp #(.MEM_AW(AW), .LATENCY(L1), .QDEPTH(QD)) u_l3 (.clk(clk), .reset(reset), .bus(bus1));

  logic [1:0]  rq, wi;
  logic [3:0]  st [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [1:0]  sz [2];
  logic [1:0]  aokv;

  assign bus0.req = rq[0]; assign bus0.wr = wi[0]; assign bus0.wstrb = st[0];
  assign bus0.addr = ad[0]; assign bus0.wdata = wd[0]; assign bus0.size = sz[0];
  assign bus1.req = rq[1]; assign bus1.wr = wi[1]; assign bus1.wstrb = st[1];
  assign bus1.addr = ad[1]; assign bus1.wdata = wd[1]; assign bus1.size = sz[1];
  assign aokv = {bus1.addr_ok, bus0.addr_ok};

  int errors = 0;
  int checks = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: outstanding requests in acceptance order, plus a
  // word-addressed memory image updated when each write is answered.
  typedef struct { longint acc; bit wr; bit [3:0] st; int idx; bit [31:0] wd; } m_t;
  typedef struct { longint c; logic [31:0] rd; } o_t;
  m_t      q       [2][$];
  o_t      obs     [2][$];
  longint  acc_log [2][$];
  bit [31:0] mm [2][1<<AW];
  bit        mv [2][1<<AW];

  function automatic int lat(input int d);
    return (d == 0) ? L0 : L1;
  endfunction

  function automatic void chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    end
  endfunction

  function automatic void chk1(input string nm, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %b expected %b", nm, d, act, exp);
    end
  endfunction

  function automatic void mon(input int d, input logic aok, input logic dok, input logic [31:0] rdv);
    m_t m;
    bit due, eaok;
    if (reset) begin
      chk1("rst_addr_ok", d, aok, 1'b0);
      chk1("rst_data_ok", d, dok, 1'b0);
      chk("rst_rdata", d, rdv, 32'h0);
      q[d].delete();
      return;
    end
    eaok = (q[d].size() < QD);
    due  = 1'b0;
    if (q[d].size() > 0) due = (cyc >= q[d][0].acc + lat(d));
`ifdef DSRAM_RAND_DELAY_EN
    if (!eaok) chk1("addr_ok_while_full", d, aok, 1'b0);
    if (!due)  chk1("data_ok_not_due", d, dok, 1'b0);
`else
    chk1("addr_ok", d, aok, eaok);
    chk1("data_ok", d, dok, due);
`endif
    if (dok && q[d].size() > 0) begin
      m = q[d].pop_front();
      if (m.wr) chk("wr_rdata", d, rdv, 32'h0);
      else if (mv[d][m.idx]) chk("rd_rdata", d, rdv, mm[d][m.idx]);
      obs[d].push_back('{c: cyc, rd: rdv});
      if (m.wr) begin
        for (int b = 0; b < 4; b++)
          if (m.st[b]) mm[d][m.idx][8*b +: 8] = m.wd[8*b +: 8];
        if (m.st == 4'hF) mv[d][m.idx] = 1'b1;
      end
    end
    if (rq[d] && aok) begin
      q[d].push_back('{acc: cyc, wr: wi[d], st: st[d], idx: int'(ad[d][AW+1:2]), wd: wd[d]});
      acc_log[d].push_back(cyc);
    end
  endfunction

  always @(negedge clk) begin
    mon(0, bus0.addr_ok, bus0.data_ok, bus0.rdata);
    mon(1, bus1.addr_ok, bus1.data_ok, bus1.rdata);
  end

  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] data, input logic [3:0] s);
    int n;
    n = 0;
    rq[d] = 1'b1; wi[d] = w; ad[d] = a; wd[d] = data; st[d] = s;
    sz[d] = 2'($urandom_range(0, 2));
    @(negedge clk);
    while (!aokv[d] && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!aokv[d]) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: addr_ok low for %0d cycles, required within 64", d, n);
    end
    @(posedge clk); #1;
    rq[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Random address in an 8-word pool, with random wrapped-away high bits
  // and random byte offset.
  function automatic logic [31:0] pool_addr(input int i);
    logic [31:0] r;
    r = $urandom;
    return (r & 32'hFFFF_C000) | 32'h0000_2000 | (32'(i) << 2) | (r & 32'h3);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rq = '0; wi = '0;
    for (int d = 0; d < 2; d++) begin st[d] = '0; ad[d] = '0; wd[d] = '0; sz[d] = '0; end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
`ifndef DSRAM_RAND_DELAY_EN
    chk1("aok_after_reset", 0, aokv[0], 1'b1);
    chk1("aok_after_reset", 1, aokv[1], 1'b1);
`endif
    @(posedge clk); #1;

    // write then read same word, back-to-back
    obs[0].delete();
    issue(0, 1'b1, 32'h100, 32'h11223344, 4'hF);
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF);
    idle(4);
    chk("r032_nresp", 0, obs[0].size(), 2);
    if (obs[0].size() == 2) begin
      chk("r032_wr_rdata", 0, obs[0][0].rd, 32'h0);
      chk("r032_rdata", 0, obs[0][1].rd, 32'h11223344);
`ifndef DSRAM_RAND_DELAY_EN
      chk("r032_gap", 0, 32'(obs[0][1].c - obs[0][0].c), 1);
`endif
    end

    // byte-strobe merge
    obs[0].delete();
    issue(0, 1'b1, 32'h200, 32'hAABBCCDD, 4'hF);
    issue(0, 1'b1, 32'h200, 32'h000000EE, 4'h1);
    issue(0, 1'b0, 32'h202, 32'h0, 4'h0);
    idle(4);
    chk("r033_nresp", 0, obs[0].size(), 3);
    if (obs[0].size() == 3) chk("r033_rdata", 0, obs[0][2].rd, 32'hAABBCCEE);

    // address wrap modulo depth
    obs[0].delete();
    issue(0, 1'b1, 32'h0000_0004, 32'h5A5A5A5A, 4'hF);
    issue(0, 1'b0, 32'h0000_4004, 32'h0, 4'hF);
    idle(4);
    chk("r036_nresp", 0, obs[0].size(), 2);
    if (obs[0].size() == 2) chk("r036_rdata", 0, obs[0][1].rd, 32'h5A5A5A5A);

    // LATENCY=3, req held across 3 requests into a 2-deep queue
    obs[1].delete(); acc_log[1].delete();
    issue(1, 1'b1, 32'h10, 32'h1, 4'hF);
    issue(1, 1'b1, 32'h14, 32'h2, 4'hF);
    issue(1, 1'b0, 32'h10, 32'h0, 4'hF);
    idle(6);
    chk("r034_nacc", 1, acc_log[1].size(), 3);
    chk("r034_nresp", 1, obs[1].size(), 3);
    if (obs[1].size() == 3 && acc_log[1].size() == 3) begin
      chk("r034_rd1", 1, obs[1][0].rd, 32'h0);
      chk("r034_rd3", 1, obs[1][2].rd, 32'h1);
`ifndef DSRAM_RAND_DELAY_EN
      chk("r034_acc2", 1, 32'(acc_log[1][1] - acc_log[1][0]), 1);
      chk("r034_acc3", 1, 32'(acc_log[1][2] - acc_log[1][0]), 4);
      chk("r034_resp1", 1, 32'(obs[1][0].c - acc_log[1][0]), 3);
      chk("r034_resp2", 1, 32'(obs[1][1].c - acc_log[1][0]), 4);
      chk("r034_resp3", 1, 32'(obs[1][2].c - acc_log[1][0]), 7);
`endif
    end

    // reset while a read is pending: dropped, memory retained
    obs[1].delete();
    issue(1, 1'b0, 32'h14, 32'h0, 4'hF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(6);
    chk("r035_dropped", 1, obs[1].size(), 0);
    issue(1, 1'b0, 32'h10, 32'h0, 4'hF);
    obs[0].delete();
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF);
    idle(8);
    chk("r035_nresp", 1, obs[1].size(), 1);
    if (obs[1].size() == 1) chk("r035_retained", 1, obs[1][0].rd, 32'h1);
    chk("r035_nresp", 0, obs[0].size(), 1);
    if (obs[0].size() == 1) chk("r035_retained", 0, obs[0][0].rd, 32'h11223344);

    // random traffic against the model
    for (int d = 0; d < 2; d++) begin
      obs[d].delete();
      for (int i = 0; i < 8; i++) issue(d, 1'b1, pool_addr(i), $urandom, 4'hF);
      for (int n = 0; n < 200; n++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        issue(d, 1'($urandom_range(0, 1)), pool_addr($urandom_range(0, 7)),
              $urandom, 4'($urandom_range(0, 15)));
      end
      idle(30);
      chk("rand_drained", d, q[d].size(), 0);
      chk("rand_nresp", d, obs[d].size(), 208);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
